// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the block RAM and its lane aligner.
package mem_pkg;

    // Access size encodings carried on req_size; 2'b11 is reserved and faults.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // INIT sweeps the array with the fill word, IDLE serves requests.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // MOV PC, #0: a stray fetch from unwritten memory jumps back to reset.
    localparam logic [31:0] DEFAULT_FILL_WORD = 32'he3a0f000;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: write enables and data shifted up into
// the addressed lanes, and read data shifted down and zero-extended.
// The write side uses the live request; the read side uses the offset and
// size captured on the accepting edge, because the raw word arrives a cycle later.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  req_lo,
    input  logic [1:0]  req_size,
    input  logic [31:0] wdata,
    input  logic [1:0]  rsp_lo,
    input  logic [1:0]  rsp_size,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misalign,
    output logic [31:0] rdata
);

    logic [31:0] rword_sh;

    assign wdata_lane = wdata << {req_lo, 3'b000};
    assign rword_sh   = rword >> {rsp_lo, 3'b000};

    // Lane enables and alignment check; reserved size enables nothing and faults.
    always_comb begin
        be       = 4'b0000;
        misalign = 1'b0;
        case (req_size)
            SIZE_BYTE: be = 4'b0001 << req_lo;
            SIZE_HALF: begin
                be       = 4'b0011 << req_lo;
                misalign = req_lo[0];
            end
            SIZE_WORD: begin
                be       = 4'b1111;
                misalign = |req_lo;
            end
            default:   misalign = 1'b1;
        endcase
    end

    // Keep only the bytes of the captured size; upper bits read as zero.
    always_comb begin
        rdata = 32'h0;
        case (rsp_size)
            SIZE_BYTE: rdata = {24'h0, rword_sh[7:0]};
            SIZE_HALF: rdata = {16'h0, rword_sh[15:0]};
            SIZE_WORD: rdata = rword_sh;
            default:   rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/block_memory.sv
// Word-organised single-port RAM with byte/halfword/word access, a hardware
// init sweep after reset or clear, and a registered one-cycle response.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on the FSM state (high in
// IDLE), never on req_valid. Every transferred request produces exactly one
// resp_valid pulse in the cycle right after its accepting edge; there is no
// response backpressure.
module block_memory
    import mem_pkg::*;
#(
    parameter int          NUM_OF_BYTES = 4096,
    parameter logic [31:0] FILL_WORD    = DEFAULT_FILL_WORD
) (
    input  logic        clk,
    input  logic        mem_reset_n,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        init_done,
    output logic        dbg_state
);

    localparam int AW    = $clog2(NUM_OF_BYTES);
    localparam int IW    = AW - 2;
    localparam int DEPTH = NUM_OF_BYTES / 4;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   cnt, cnt_nxt;
    logic            init_we;

    logic            accept, oor, misalign, fault, wr_en, rd_en;
    logic [3:0]      lane_be;
    logic [31:0]     wdata_lane, rdata_al;

    logic [IW-1:0]   port_idx;
    logic [3:0]      port_be;
    logic [31:0]     port_wd;
    logic [31:0]     mem [DEPTH];
    logic [31:0]     rd_word;

    logic            rd_q;
    logic [1:0]      rsp_lo, rsp_size;

    assign dbg_state = state;
    assign accept    = req_valid & req_ready;
    assign oor       = |req_addr[31:AW];
    assign fault     = oor | misalign;
    assign wr_en     = accept & req_write & ~fault;
    assign rd_en     = accept & ~req_write & ~fault;

    mem_lane_align u_align (
        .req_lo     (req_addr[1:0]),
        .req_size   (req_size),
        .wdata      (req_wdata),
        .rsp_lo     (rsp_lo),
        .rsp_size   (rsp_size),
        .rword      (rd_word),
        .be         (lane_be),
        .wdata_lane (wdata_lane),
        .misalign   (misalign),
        .rdata      (rdata_al)
    );

    // State, sweep counter and init_done; init_done tracks "next state is IDLE".
    always_ff @(posedge clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_done <= (state_nxt == ST_IDLE);
        end
    end

    // Next state: sweep one word per cycle in INIT, accept requests in IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        init_we   = 1'b0;
        case (state)
            ST_INIT: begin
                if (clear) begin
                    cnt_nxt = '0;
                end else begin
                    init_we = 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + IW'(1);
                    end
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (clear) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Single array port shared by the init sweep and requests.
    always_comb begin
        port_idx = cnt;
        port_be  = 4'b0000;
        port_wd  = FILL_WORD;
        if (init_we) begin
            port_be = 4'b1111;
        end else begin
            port_idx = req_addr[AW-1:2];
            if (wr_en) begin
                port_be = lane_be;
                port_wd = wdata_lane;
            end
        end
    end

    // Array with per-lane write enables and a registered read (no reset, BRAM style).
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (port_be[i]) begin
                mem[port_idx][8*i +: 8] <= port_wd[8*i +: 8];
            end
        end
        if (rd_en) begin
            rd_word <= mem[port_idx];
        end
    end

    // Response flags and the read offset/size captured on the accepting edge.
    always_ff @(posedge clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            rd_q       <= 1'b0;
            rsp_lo     <= 2'b00;
            rsp_size   <= SIZE_BYTE;
        end else begin
            resp_valid <= accept;
            resp_fault <= accept & fault;
            rd_q       <= rd_en;
            if (accept) begin
                rsp_lo   <= req_addr[1:0];
                rsp_size <= req_size;
            end
        end
    end

    // Writes and faults answer with zero data.
    assign resp_rdata = rd_q ? rdata_al : 32'h0;

endmodule

// File: tb/tb_block_memory.sv
// Bench for block_memory with a 64-byte array: directed cases, sweep timing
// around reset and clear, and a short random phase against a byte model.
module tb_block_memory;

    localparam int NB    = 64;
    localparam int DEPTH = NB / 4;
    localparam logic [31:0] FILL = 32'he3a0f000;

    logic        clk;
    logic        mem_reset_n;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        init_done;
    logic        dbg_state;

    block_memory #(.NUM_OF_BYTES(NB)) dut (
        .clk        (clk),
        .mem_reset_n(mem_reset_n),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .init_done  (init_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic        fault_q[$];
    int          due_q[$];
    logic [31:0] model [DEPTH];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_fill();
        for (int i = 0; i < DEPTH; i++) model[i] = FILL;
    endfunction

    // Reference behaviour: returns {fault, rdata} and applies writes to the model.
    function automatic logic [32:0] model_apply(input logic w, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        int n;
        int idx;
        int lo;
        logic [31:0] d;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (a >= NB || sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00))
            return {1'b1, 32'h0};
        idx = int'(a[5:2]);
        lo  = int'(a[1:0]);
        d   = 32'h0;
        for (int k = 0; k < n; k++) begin
            if (w) model[idx][8*(lo+k) +: 8] = wd[8*k +: 8];
            else   d[8*k +: 8] = model[idx][8*(lo+k) +: 8];
        end
        return {1'b0, d};
    endfunction

    // ---------------- driver tasks ----------------
    // Drives one request at a negedge; it transfers on the following posedge.
    task automatic send(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [32:0] exp);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            req_valid = 1'b0;
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        exp_q.push_back(exp[31:0]);
        fault_q.push_back(exp[32]);
        due_q.push_back(cyc + 1);
    endtask

    task automatic send_exp(input logic w, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] ed, input logic ef);
        void'(model_apply(w, sz, a, wd));
        send(w, sz, a, wd, {ef, ed});
    endtask

    task automatic go_idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts DEPTH edges from the current point: ready low until the last one.
    task automatic wait_sweep(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            #1;
            check(tag, {31'h0, req_ready}, {31'h0, i == DEPTH});
        end
        check({tag, "_done"}, {31'h0, init_done}, 32'd1);
    endtask

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_resp", 32'd1, 32'd0);
            end else begin
                logic [31:0] d;
                logic        f;
                int          t;
                d = exp_q.pop_front();
                f = fault_q.pop_front();
                t = due_q.pop_front();
                check("resp_cycle", cyc, t);
                check("resp_rdata", resp_rdata, d);
                check("resp_fault", {31'h0, resp_fault}, {31'h0, f});
            end
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            check("resp_missing", 32'd0, 32'd1);
            void'(exp_q.pop_front());
            void'(fault_q.pop_front());
            void'(due_q.pop_front());
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        mem_reset_n = 1'b0;
        clear       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'b00;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        model_fill();

        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'd0);
        check("rst_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_fault", {31'h0, resp_fault}, 32'd0);
        check("rst_init_done", {31'h0, init_done}, 32'd0);
        mem_reset_n = 1'b1;
        wait_sweep("boot_sweep");
        check("boot_state", {31'h0, dbg_state}, 32'd1);

        // Fill visible at the top word
        send_exp(1'b0, 2'b10, 32'h3C, 32'h0, FILL, 1'b0);

        // Byte merge into a written word
        send_exp(1'b1, 2'b10, 32'h10, 32'h11223344, 32'h0, 1'b0);
        send_exp(1'b1, 2'b00, 32'h12, 32'h000000AA, 32'h0, 1'b0);
        send_exp(1'b0, 2'b10, 32'h10, 32'h0, 32'h11AA3344, 1'b0);

        // Halfword in the upper lanes
        send_exp(1'b1, 2'b01, 32'h06, 32'h0000BEEF, 32'h0, 1'b0);
        send_exp(1'b0, 2'b01, 32'h06, 32'h0, 32'h0000BEEF, 1'b0);
        send_exp(1'b0, 2'b00, 32'h07, 32'h0, 32'h000000BE, 1'b0);
        send_exp(1'b0, 2'b01, 32'h04, 32'h0, 32'h0000F000, 1'b0);

        // Faults: misaligned word, misaligned half write, out of range, reserved size
        send_exp(1'b0, 2'b10, 32'h02, 32'h0, 32'h0, 1'b1);
        send_exp(1'b1, 2'b01, 32'h05, 32'h00001234, 32'h0, 1'b1);
        send_exp(1'b0, 2'b10, 32'h04, 32'h0, 32'hBEEFF000, 1'b0);
        send_exp(1'b0, 2'b10, 32'h40, 32'h0, 32'h0, 1'b1);
        send_exp(1'b0, 2'b11, 32'h00, 32'h0, 32'h0, 1'b1);

        // Back-to-back reads
        send_exp(1'b0, 2'b10, 32'h00, 32'h0, FILL, 1'b0);
        send_exp(1'b0, 2'b10, 32'h04, 32'h0, 32'hBEEFF000, 1'b0);
        send_exp(1'b0, 2'b10, 32'h08, 32'h0, FILL, 1'b0);

        // Clear together with a read: the read completes, then the sweep runs
        send_exp(1'b1, 2'b10, 32'h20, 32'h12345678, 32'h0, 1'b0);
        send_exp(1'b0, 2'b10, 32'h20, 32'h0, 32'h12345678, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        req_valid = 1'b0;
        model_fill();
        check("clr_ready", {31'h0, req_ready}, 32'd0);
        check("clr_init_done", {31'h0, init_done}, 32'd0);
        wait_sweep("clear_sweep");
        send_exp(1'b0, 2'b10, 32'h20, 32'h0, FILL, 1'b0);
        go_idle();

        // Clear in the middle of a sweep restarts the count
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("reclr_ready", {31'h0, req_ready}, 32'd0);
        wait_sweep("reclear_sweep");

        // Reset in the middle of a sweep restarts from word 0
        send_exp(1'b1, 2'b10, 32'h0C, 32'hCAFEF00D, 32'h0, 1'b0);
        go_idle();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        mem_reset_n = 1'b0;
        #1;
        check("midrst_ready", {31'h0, req_ready}, 32'd0);
        check("midrst_init_done", {31'h0, init_done}, 32'd0);
        check("midrst_valid", {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        mem_reset_n = 1'b1;
        model_fill();
        wait_sweep("reset_sweep");
        send_exp(1'b0, 2'b10, 32'h0C, 32'h0, FILL, 1'b0);

        // Random accesses against the model
        for (int i = 0; i < 32; i++) begin
            logic        w;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [31:0] wd;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 71));
            wd = $urandom;
            send(w, sz, a, wd, model_apply(w, sz, a, wd));
        end
        go_idle();

        repeat (3) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
